// File: rtl/hb_decim2.sv
// 11-tap halfband low-pass, decimate-by-2, using one time-multiplexed MAC.
// Sits after the CIC decimator; emits one rounded, saturated sample per two accepted inputs.
module hb_decim2 #(
  parameter int                 DW = 16,
  parameter logic signed [15:0] C0 = 16'sd302,
  parameter logic signed [15:0] C1 = -16'sd2090,
  parameter logic signed [15:0] C2 = 16'sd9980,
  parameter logic signed [15:0] CC = 16'sd16384
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  output logic                 overrun
);

  localparam int TAPS = 11;
  localparam int CW   = 16;
  localparam int SW   = DW + 1;
  localparam int PW   = SW + CW;
  localparam int AW   = PW + 3;
  localparam int FRAC = 15;

  localparam logic signed [AW-1:0] RND     = AW'(2 ** (FRAC - 1));
  localparam logic signed [AW-1:0] OUT_MAX = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] OUT_MIN = -OUT_MAX - AW'(1);

  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_OUT} state_e;

  state_e               state_q, state_d;
  logic                 start_q, start_d;
  logic                 phase_q, phase_d;
  logic                 overrun_q, overrun_d;
  logic                 dout_valid_q, dout_valid_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] x_q [TAPS];

  logic                 ready;
  logic                 accept;
  logic signed [SW-1:0] opa;
  logic signed [CW-1:0] coef;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] acc_fin;
  logic signed [AW-1:0] rounded;
  logic signed [AW-1:0] shifted;
  logic signed [DW-1:0] sat_val;

  function automatic logic signed [SW-1:0] pair_sum(input logic signed [DW-1:0] a,
                                                    input logic signed [DW-1:0] b);
    return $signed({a[DW-1], a}) + $signed({b[DW-1], b});
  endfunction

  // start_q covers the cycle between the trigger edge and entry into P0, so the
  // block is busy for four edges; OUT already accepts, as the FSM is leaving.
  assign ready  = ((state_q == S_IDLE) && !start_q) || (state_q == S_OUT);
  assign accept = din_valid && ready;

  always_comb begin
    opa  = '0;
    coef = '0;
    case (state_q)
      S_P0:    begin opa = pair_sum(x_q[0], x_q[10]); coef = C0; end
      S_P1:    begin opa = pair_sum(x_q[2], x_q[8]);  coef = C1; end
      S_P2:    begin opa = pair_sum(x_q[4], x_q[6]);  coef = C2; end
      S_OUT:   begin opa = $signed({x_q[5][DW-1], x_q[5]}); coef = CC; end
      default: ;
    endcase
  end

  assign prod     = opa * coef;
  assign prod_ext = $signed({{(AW-PW){prod[PW-1]}}, prod});
  assign acc_fin  = acc_q + prod_ext;
  assign rounded  = acc_fin + RND;
  assign shifted  = rounded >>> FRAC;

  always_comb begin
    if (shifted > OUT_MAX)      sat_val = OUT_MAX[DW-1:0];
    else if (shifted < OUT_MIN) sat_val = OUT_MIN[DW-1:0];
    else                        sat_val = shifted[DW-1:0];
  end

  // NOTE: every next-state signal takes its hold value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    phase_d      = phase_q;
    overrun_d    = overrun_q;
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (din_valid && !ready) overrun_d = 1'b1;
    if (accept) begin
      phase_d = ~phase_q;
      start_d = phase_q;
    end

    case (state_q)
      S_IDLE: if (start_q) state_d = S_P0;
      S_P0: begin
        acc_d   = prod_ext;
        state_d = S_P1;
      end
      S_P1: begin
        acc_d   = acc_fin;
        state_d = S_P2;
      end
      S_P2: begin
        acc_d   = acc_fin;
        state_d = S_OUT;
      end
      S_OUT: begin
        acc_d        = acc_fin;
        dout_d       = sat_val;
        dout_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      phase_q      <= 1'b0;
      overrun_q    <= 1'b0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      phase_q      <= phase_d;
      overrun_q    <= overrun_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // NOTE: the delay line is cleared on reset so the first outputs after reset
  // are the filter's response to zero history, not to stale samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[0] <= din;
      for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule
